// File: rtl/updown_mod_counter.sv
// Up/down modulo-(MAX_VAL+1) counter: y updates 1 cycle after the sampled controls, tc is combinational.
// No backpressure. Define UPDOWN_MOD_COUNTER_SAT_EN to saturate at the bounds instead of wrapping.
module updown_mod_counter #(
  parameter int WIDTH   = 8,
  parameter int MAX_VAL = 2**WIDTH-1,
  parameter int RST_VAL = 0
) (
  input  logic             clk,
  input  logic             ret,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic             pre,
  input  logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] y,
  output logic             tc,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] RST_V = WIDTH'(RST_VAL);
  localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);

  logic [WIDTH-1:0] y_nxt;
  logic             at_max;
  logic             at_zero;

  assign at_max  = (y == MAX_V);
  assign at_zero = (y == '0);
  assign tc      = up ? at_max : at_zero;

`ifdef UPDOWN_MOD_COUNTER_SAT_EN
  always_comb begin
    y_nxt = y;
    if (pre) begin
      y_nxt = MAX_V;
    end else if (load) begin
      y_nxt = (a > MAX_V) ? MAX_V : a;
    end else if (en) begin
      // At a bound the count simply holds.
      if (up && !at_max) begin
        y_nxt = y + ONE;
      end else if (!up && !at_zero) begin
        y_nxt = y - ONE;
      end
    end
  end

  assign wrap = 1'b0;

  always_ff @(posedge clk or negedge ret) begin
    if (!ret) begin
      y <= RST_V;
    end else begin
      y <= y_nxt;
    end
  end
`else
  logic wrap_nxt;

  always_comb begin
    y_nxt    = y;
    wrap_nxt = 1'b0;
    if (pre) begin
      y_nxt = MAX_V;
    end else if (load) begin
      y_nxt = (a > MAX_V) ? MAX_V : a;
    end else if (en) begin
      // Wrap at MAX_VAL, not at 2**WIDTH, so y never leaves 0..MAX_VAL.
      if (up) begin
        if (at_max) begin
          y_nxt    = '0;
          wrap_nxt = 1'b1;
        end else begin
          y_nxt = y + ONE;
        end
      end else begin
        if (at_zero) begin
          y_nxt    = MAX_V;
          wrap_nxt = 1'b1;
        end else begin
          y_nxt = y - ONE;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge ret) begin
    if (!ret) begin
      y    <= RST_V;
      wrap <= 1'b0;
    end else begin
      y    <= y_nxt;
      wrap <= wrap_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_updown_mod_counter.sv
// Bench for updown_mod_counter at WIDTH=4, MAX_VAL=9: directed scenarios plus random stimulus vs. an arithmetic model.
module tb_updown_mod_counter;

  localparam int W    = 4;
  localparam int MAXV = 9;

  logic         clk = 1'b0;
  logic         ret = 1'b1;
  logic         en = 1'b0, up = 1'b0, load = 1'b0, pre = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] y;
  logic         tc, wrap;

  int vectors    = 0;
  int miscompares = 0;

  // Reference model state: count value and the pulse expected after the last edge.
  int m_y    = 0;
  bit m_wrap = 1'b0;

  updown_mod_counter #(.WIDTH(W), .MAX_VAL(MAXV), .RST_VAL(0)) dut (
    .clk(clk), .ret(ret), .en(en), .up(up), .load(load), .pre(pre),
    .a(a), .y(y), .tc(tc), .wrap(wrap)
  );

  always #5 clk = ~clk;

  function automatic bit exp_tc();
    return up ? (m_y == MAXV) : (m_y == 0);
  endfunction

  // Drive one edge's controls, advance the model at the edge, return at the following negedge.
  task automatic step(input bit p, input bit l, input bit e, input bit u, input int av);
    pre = p; load = l; en = e; up = u; a = W'(av);
    @(posedge clk);
    if (p) begin
      m_y = MAXV; m_wrap = 1'b0;
    end else if (l) begin
      m_y = (av > MAXV) ? MAXV : av; m_wrap = 1'b0;
    end else if (e) begin
`ifdef UPDOWN_MOD_COUNTER_SAT_EN
      m_wrap = 1'b0;
      if (u) m_y = (m_y == MAXV) ? MAXV : m_y + 1;
      else   m_y = (m_y == 0) ? 0 : m_y - 1;
`else
      m_wrap = u ? (m_y == MAXV) : (m_y == 0);
      m_y    = u ? (m_y + 1) % (MAXV + 1) : (m_y + MAXV) % (MAXV + 1);
`endif
    end else begin
      m_wrap = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    #1 ret = 1'b0;
    #2;
    vectors++;
    if (y !== 4'd0) begin miscompares++; $display("FAIL reset_async_y got=%0d exp=0", y); end
    vectors++;
    if (wrap !== 1'b0) begin miscompares++; $display("FAIL reset_async_wrap got=%b exp=0", wrap); end
    en = 1'b1; up = 1'b1;
    repeat (2) @(negedge clk);
    vectors++;
    if (y !== 4'd0) begin miscompares++; $display("FAIL reset_held_y got=%0d exp=0", y); end
    up = 1'b0; #1;
    vectors++;
    if (tc !== 1'b1) begin miscompares++; $display("FAIL reset_tc got=%b exp=1", tc); end
    en = 1'b0;
    ret = 1'b1; m_y = 0; m_wrap = 1'b0;
  endtask

`ifndef UPDOWN_MOD_COUNTER_SAT_EN
  task automatic test_count_up();
    int ey[5] = '{7, 8, 9, 0, 1};
    bit ew[5] = '{0, 0, 0, 1, 0};
    bit et[5] = '{0, 0, 1, 0, 0};
    for (int i = 0; i < 5; i++) begin
      if (i == 0) step(0, 1, 1, 1, 7);
      else        step(0, 0, 1, 1, 0);
      vectors++;
      if (y !== W'(ey[i])) begin miscompares++; $display("FAIL up_y[%0d] got=%0d exp=%0d", i, y, ey[i]); end
      vectors++;
      if (wrap !== ew[i]) begin miscompares++; $display("FAIL up_wrap[%0d] got=%b exp=%b", i, wrap, ew[i]); end
      vectors++;
      if (tc !== et[i]) begin miscompares++; $display("FAIL up_tc[%0d] got=%b exp=%b", i, tc, et[i]); end
    end
  endtask

  task automatic test_count_down();
    int ey[3] = '{0, 9, 8};
    bit ew[3] = '{0, 1, 0};
    bit et[3] = '{1, 0, 0};
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 1, 0, 0);
      vectors++;
      if (y !== W'(ey[i])) begin miscompares++; $display("FAIL dn_y[%0d] got=%0d exp=%0d", i, y, ey[i]); end
      vectors++;
      if (wrap !== ew[i]) begin miscompares++; $display("FAIL dn_wrap[%0d] got=%b exp=%b", i, wrap, ew[i]); end
      vectors++;
      if (tc !== et[i]) begin miscompares++; $display("FAIL dn_tc[%0d] got=%b exp=%b", i, tc, et[i]); end
    end
  endtask
`else
  task automatic test_saturation();
    step(0, 1, 0, 1, 8);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 1, 1, 0);
      vectors++;
      if (y !== 4'd9) begin miscompares++; $display("FAIL sat_up_y[%0d] got=%0d exp=9", i, y); end
      vectors++;
      if (wrap !== 1'b0) begin miscompares++; $display("FAIL sat_up_wrap[%0d] got=%b exp=0", i, wrap); end
    end
    step(0, 1, 0, 0, 1);
    for (int i = 0; i < 2; i++) begin
      step(0, 0, 1, 0, 0);
      vectors++;
      if (y !== 4'd0) begin miscompares++; $display("FAIL sat_dn_y[%0d] got=%0d exp=0", i, y); end
      vectors++;
      if (wrap !== 1'b0) begin miscompares++; $display("FAIL sat_dn_wrap[%0d] got=%b exp=0", i, wrap); end
    end
  endtask
`endif

  task automatic test_load_clamp();
    int ev[3] = '{9, 9, 3};
    for (int i = 0; i < 3; i++) begin
      case (i)
        0:       step(0, 1, 0, 0, 12);
        1:       step(1, 1, 1, 0, 3);
        default: step(0, 1, 0, 0, 3);
      endcase
      vectors++;
      if (y !== W'(ev[i])) begin miscompares++; $display("FAIL load_y[%0d] got=%0d exp=%0d", i, y, ev[i]); end
      vectors++;
      if (wrap !== 1'b0) begin miscompares++; $display("FAIL load_wrap[%0d] got=%b exp=0", i, wrap); end
    end
  endtask

  task automatic test_async_reset();
    step(0, 1, 0, 0, 5);
    step(0, 0, 1, 1, 0);
    vectors++;
    if (y !== 4'd6) begin miscompares++; $display("FAIL arst_pre_y got=%0d exp=6", y); end
    #2 ret = 1'b0;
    #1;
    vectors++;
    if (y !== 4'd0) begin miscompares++; $display("FAIL arst_mid_y got=%0d exp=0", y); end
    ret = 1'b1; m_y = 0; m_wrap = 1'b0;
    // Reach a state where wrap is high (default build), then reset mid-cycle.
    step(0, 0, 1, 0, 0);
    vectors++;
    if (wrap !== m_wrap) begin miscompares++; $display("FAIL arst_wrap_pre got=%b exp=%b", wrap, m_wrap); end
    #2 ret = 1'b0;
    #1;
    vectors++;
    if (wrap !== 1'b0) begin miscompares++; $display("FAIL arst_wrap_clr got=%b exp=0", wrap); end
    vectors++;
    if (y !== 4'd0) begin miscompares++; $display("FAIL arst_wrap_y got=%0d exp=0", y); end
    en = 1'b1; up = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vectors++;
      if (y !== 4'd0) begin miscompares++; $display("FAIL arst_hold_y[%0d] got=%0d exp=0", i, y); end
    end
    ret = 1'b1; m_y = 0; m_wrap = 1'b0;
  endtask

  task automatic test_hold();
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 0, i[0], $urandom_range(15));
      vectors++;
      if (y !== 4'd0) begin miscompares++; $display("FAIL hold_y[%0d] got=%0d exp=0", i, y); end
      vectors++;
      if (wrap !== 1'b0) begin miscompares++; $display("FAIL hold_wrap[%0d] got=%b exp=0", i, wrap); end
      vectors++;
      if (tc !== !up) begin miscompares++; $display("FAIL hold_tc[%0d] got=%b exp=%b", i, tc, !up); end
      up = ~up; #1;
      vectors++;
      if (tc !== !up) begin miscompares++; $display("FAIL hold_tc_comb[%0d] got=%b exp=%b", i, tc, !up); end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(7) == 0, $urandom_range(4) == 0, $urandom_range(3) != 0,
           $urandom_range(1) == 1, $urandom_range(15));
      vectors++;
      if (y !== W'(m_y)) begin miscompares++; $display("FAIL rnd_y[%0d] got=%0d exp=%0d", i, y, m_y); end
      vectors++;
      if (wrap !== m_wrap) begin miscompares++; $display("FAIL rnd_wrap[%0d] got=%b exp=%b", i, wrap, m_wrap); end
      vectors++;
      if (tc !== exp_tc()) begin miscompares++; $display("FAIL rnd_tc[%0d] got=%b exp=%b", i, tc, exp_tc()); end
    end
  endtask

  task automatic test_back_to_back_wrap();
    // Flipping direction on consecutive edges at a bound crosses twice in a row.
    step(0, 1, 0, 0, 9);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 1, i[0] == 1'b0, 0);
      vectors++;
      if (y !== W'(m_y)) begin miscompares++; $display("FAIL b2b_y[%0d] got=%0d exp=%0d", i, y, m_y); end
      vectors++;
      if (wrap !== m_wrap) begin miscompares++; $display("FAIL b2b_wrap[%0d] got=%b exp=%b", i, wrap, m_wrap); end
    end
  endtask

  initial begin
    test_reset();
`ifndef UPDOWN_MOD_COUNTER_SAT_EN
    test_count_up();
    test_count_down();
`else
    test_saturation();
`endif
    test_load_clamp();
    test_async_reset();
    test_hold();
    test_back_to_back_wrap();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
